// File: rtl/nonce_dispatcher.sv
// Hands out 2^CHUNK_LOG2-nonce ranges to idle hash cores in round-robin order and
// funnels the cores' found nonces, lowest core first, into an ordered result FIFO.
module nonce_dispatcher #(
    parameter int NUM_CORES  = 4,
    parameter int CHUNK_LOG2 = 20,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic                   job_start,
    input  logic                   job_stop,
    input  logic [31:0]            nonce_base,
    input  logic [31:0]            nonce_limit,
    input  logic [NUM_CORES-1:0]   core_req,
    output logic [NUM_CORES-1:0]   core_grant,
    output logic [31:0]            core_nonce_start,
    output logic [31:0]            core_nonce_end,
    input  logic [NUM_CORES-1:0]   core_found,
    input  logic [32*NUM_CORES-1:0] core_found_nonce,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_nonce,
    output logic [IDX_W-1:0]       res_core,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [32:0] CHUNK = 33'(1) << CHUNK_LOG2;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_e;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % NUM_CORES);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_e                       state_q, state_d;
    logic [31:0]                  next_nonce_q, next_nonce_d;
    logic [31:0]                  limit_q, limit_d;
    logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0]         grant_q, grant_d;
    logic [31:0]                  start_q, start_d;
    logic [31:0]                  end_q, end_d;
    logic                         done_q, done_d;
    logic                         overflow_q, overflow_d;
    logic [NUM_CORES-1:0][1:0]    mask_cnt_q, mask_cnt_d;

    logic [NUM_CORES-1:0]         pend_valid_q, pend_valid_d;
    logic [NUM_CORES-1:0][31:0]   pend_nonce_q, pend_nonce_d;
    logic [31:0]                  fifo_nonce_q [FIFO_DEPTH];
    logic [IDX_W-1:0]             fifo_core_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]             fifo_cnt_q, fifo_cnt_d;

    logic [NUM_CORES-1:0]         masked, eligible;
    logic                         gnt_found;
    logic [IDX_W-1:0]             gnt_idx;
    logic [32:0]                  nonce_sum, chunk_last;
    logic                         exhausted, job_clear_ovf;
    logic [NUM_CORES-1:0][31:0]   found_nonce;
    logic                         pend_any, fifo_full, fifo_push, fifo_pop, drop;
    logic [IDX_W-1:0]             pend_sel;

    assign found_nonce = core_found_nonce;

    // A just-granted core keeps core_req high for a couple of cycles before it reacts.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            masked[i] = (mask_cnt_q[i] != 2'd0);
        end
        eligible = core_req & ~masked;
    end

    // NOTE: every variable written in always_comb gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!gnt_found && eligible[wrap_idx(int'(rr_ptr_q) + k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(int'(rr_ptr_q) + k);
            end
        end
    end

    // 33-bit sum so a range ending at 0xFFFFFFFF is seen as the last one, not a wrap.
    assign nonce_sum  = {1'b0, next_nonce_q} + CHUNK;
    assign chunk_last = nonce_sum - 33'd1;
    assign exhausted  = nonce_sum[32] || (nonce_sum[31:0] > limit_q);

    always_comb begin
        state_d       = state_q;
        next_nonce_d  = next_nonce_q;
        limit_d       = limit_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = '0;
        start_d       = start_q;
        end_d         = end_q;
        done_d        = 1'b0;
        job_clear_ovf = 1'b0;
        case (state_q)
            IDLE: begin
                if (job_start) begin
                    next_nonce_d  = nonce_base;
                    limit_d       = nonce_limit;
                    job_clear_ovf = 1'b1;
                    state_d       = DISPATCH;
                end
            end
            DISPATCH: begin
                if (job_stop) begin
                    state_d = IDLE;
                end else if (next_nonce_q > limit_q) begin
                    state_d = DRAIN;
                end else if (gnt_found) begin
                    grant_d[gnt_idx] = 1'b1;
                    start_d          = next_nonce_q;
                    end_d            = (chunk_last > {1'b0, limit_q}) ? limit_q : chunk_last[31:0];
                    next_nonce_d     = nonce_sum[31:0];
                    rr_ptr_d         = wrap_idx(int'(gnt_idx) + 1);
                    if (exhausted) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (job_stop) begin
                    state_d = IDLE;
                end else if (&eligible) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_d[i]) begin
                mask_cnt_d[i] = 2'd2;
            end else if (mask_cnt_q[i] != 2'd0) begin
                mask_cnt_d[i] = mask_cnt_q[i] - 2'd1;
            end else begin
                mask_cnt_d[i] = 2'd0;
            end
        end
    end

    always_comb begin
        pend_any = 1'b0;
        pend_sel = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (pend_valid_q[i]) begin
                pend_any = 1'b1;
                pend_sel = IDX_W'(i);
            end
        end
        fifo_full = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
        fifo_pop  = (fifo_cnt_q != '0) && res_ready;
        fifo_push = pend_any && (!fifo_full || fifo_pop);

        drop         = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_nonce_d = pend_nonce_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (fifo_push && (pend_sel == IDX_W'(i))) begin
                pend_valid_d[i] = 1'b0;
            end
            if (core_found[i]) begin
                if (pend_valid_d[i]) begin
                    drop = 1'b1;
                end else begin
                    pend_valid_d[i] = 1'b1;
                    pend_nonce_d[i] = found_nonce[i];
                end
            end
        end

        overflow_d = job_clear_ovf ? 1'b0 : overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end

        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            next_nonce_q <= '0;
            limit_q      <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            start_q      <= '0;
            end_q        <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            mask_cnt_q   <= '0;
            pend_valid_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            next_nonce_q <= next_nonce_d;
            limit_q      <= limit_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            start_q      <= start_d;
            end_q        <= end_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            mask_cnt_q   <= mask_cnt_d;
            pend_valid_q <= pend_valid_d;
            fifo_cnt_q   <= fifo_cnt_d;
            if (fifo_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (fifo_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // NOTE: payload storage has no reset; the valid bits and FIFO count guard every
    // read, so stale contents are never observable.
    always_ff @(posedge clk_clk) begin
        pend_nonce_q <= pend_nonce_d;
        if (fifo_push) begin
            fifo_nonce_q[wr_ptr_q] <= pend_nonce_q[pend_sel];
            fifo_core_q[wr_ptr_q]  <= pend_sel;
        end
    end

    assign core_grant       = grant_q;
    assign core_nonce_start = start_q;
    assign core_nonce_end   = end_q;
    assign res_valid        = (fifo_cnt_q != '0);
    assign res_nonce        = res_valid ? fifo_nonce_q[rd_ptr_q] : '0;
    assign res_core         = res_valid ? fifo_core_q[rd_ptr_q] : '0;
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed bench for nonce_dispatcher: inputs change and outputs are sampled on the
// falling clock edge, one step per cycle, with hand-computed expectations.
module tb_nonce_dispatcher;

    localparam int NC = 4;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic              job_start, job_stop, res_ready;
    logic [31:0]       nonce_base, nonce_limit;
    logic [NC-1:0]     core_req, core_found, core_grant;
    logic [32*NC-1:0]  core_found_nonce;
    logic [31:0]       core_nonce_start, core_nonce_end, res_nonce;
    logic              res_valid, busy, done, overflow;
    logic [1:0]        res_core;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_start [4] = '{32'h0000_0000, 32'h0010_0000, 32'h0020_0000, 32'h0030_0000};
    logic [31:0] exp_end   [4] = '{32'h000F_FFFF, 32'h001F_FFFF, 32'h002F_FFFF, 32'h003F_FFFF};
    logic [31:0] pop_nonce [5] = '{32'h1111_0001, 32'h3333_0003, 32'h4444_0000,
                                   32'h5555_0002, 32'h6666_0001};
    logic [1:0]  pop_core  [5] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1};

    nonce_dispatcher #(.NUM_CORES(NC), .CHUNK_LOG2(20), .FIFO_DEPTH(4)) dut (
        .clk_clk          (clk_clk),
        .reset_reset_n    (reset_reset_n),
        .job_start        (job_start),
        .job_stop         (job_stop),
        .nonce_base       (nonce_base),
        .nonce_limit      (nonce_limit),
        .core_req         (core_req),
        .core_grant       (core_grant),
        .core_nonce_start (core_nonce_start),
        .core_nonce_end   (core_nonce_end),
        .core_found       (core_found),
        .core_found_nonce (core_found_nonce),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_nonce        (res_nonce),
        .res_core         (res_core),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_clk);
    endtask

    // Watches a job wind down: no grant may appear and done must pulse exactly once.
    task automatic drain_window(input string tag, input int cycles);
        int dones = 0;
        for (int c = 0; c < cycles; c++) begin
            step();
            check({tag, "_no_grant"}, 64'(core_grant), 64'd0);
            if (done === 1'b1) dones++;
        end
        check({tag, "_done_count"}, 64'(dones), 64'd1);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    task automatic check_head(input string tag, input logic [31:0] n, input logic [1:0] c);
        check({tag, "_valid"}, 64'(res_valid), 64'd1);
        check({tag, "_nonce"}, 64'(res_nonce), 64'(n));
        check({tag, "_core"}, 64'(res_core), 64'(c));
    endtask

    initial begin
        reset_reset_n    = 1'b0;
        job_start        = 1'b0;
        job_stop         = 1'b0;
        res_ready        = 1'b0;
        nonce_base       = '0;
        nonce_limit      = '0;
        core_req         = '0;
        core_found       = '0;
        core_found_nonce = '0;
        step();
        step();
        reset_reset_n = 1'b1;
        check("rst_grant", 64'(core_grant), 64'd0);
        check("rst_start", 64'(core_nonce_start), 64'd0);
        check("rst_end", 64'(core_nonce_end), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_nonce", 64'(res_nonce), 64'd0);
        check("rst_res_core", 64'(res_core), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);

        // Four full chunks to four always-requesting cores, then drain.
        nonce_base  = 32'h0000_0000;
        nonce_limit = 32'h003F_FFFF;
        core_req    = 4'hF;
        job_start   = 1'b1;
        step();
        job_start = 1'b0;
        check("r020_busy", 64'(busy), 64'd1);
        check("r020_idle_grant", 64'(core_grant), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("r020_grant", 64'(core_grant), 64'(4'b0001 << i));
            check("r020_start", 64'(core_nonce_start), 64'(exp_start[i]));
            check("r020_end", 64'(core_nonce_end), 64'(exp_end[i]));
        end
        check("r020_busy_drain", 64'(busy), 64'd1);
        drain_window("r020", 8);

        // Last chunk ends exactly at 0xFFFFFFFF: carry must end the job.
        nonce_base  = 32'hFFF0_0000;
        nonce_limit = 32'hFFFF_FFFF;
        job_start   = 1'b1;
        step();
        job_start = 1'b0;
        step();
        check("r021_grant", 64'(core_grant), 64'h1);
        check("r021_start", 64'(core_nonce_start), 64'hFFF0_0000);
        check("r021_end", 64'(core_nonce_end), 64'hFFFF_FFFF);
        drain_window("r021", 8);

        // Empty job: base above limit.
        nonce_base  = 32'h0000_0010;
        nonce_limit = 32'h0000_0008;
        job_start   = 1'b1;
        step();
        job_start = 1'b0;
        check("r022_busy", 64'(busy), 64'd1);
        drain_window("r022", 6);

        // Result path: simultaneous finds, fill FIFO, then overflow a blocked pending slot.
        core_req                    = '0;
        core_found                  = 4'b1010;
        core_found_nonce[32 +: 32]  = 32'h1111_0001;
        core_found_nonce[96 +: 32]  = 32'h3333_0003;
        step();
        core_found = '0;
        check("r023_not_yet", 64'(res_valid), 64'd0);
        step();
        check_head("r023_first", 32'h1111_0001, 2'd1);
        core_found                  = 4'b0101;
        core_found_nonce[0 +: 32]   = 32'h4444_0000;
        core_found_nonce[64 +: 32]  = 32'h5555_0002;
        step();
        core_found = '0;
        check_head("r023_stable", 32'h1111_0001, 2'd1);
        step();
        step();
        step();
        core_found                  = 4'b0010;
        core_found_nonce[32 +: 32]  = 32'h6666_0001;
        step();
        check("r023_ovf_before", 64'(overflow), 64'd0);
        core_found_nonce[32 +: 32]  = 32'h7777_0001;
        step();
        core_found = '0;
        check("r023_ovf_set", 64'(overflow), 64'd1);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_head("r023_pop", pop_nonce[i], pop_core[i]);
            step();
        end
        check("r023_empty", 64'(res_valid), 64'd0);
        check("r023_ovf_sticky", 64'(overflow), 64'd1);
        res_ready = 1'b0;

        // Stop wins over an eligible request; FIFO contents survive.
        core_found                  = 4'b0101;
        core_found_nonce[0 +: 32]   = 32'h8888_0000;
        core_found_nonce[64 +: 32]  = 32'h9999_0002;
        step();
        core_found = '0;
        step();
        step();
        check_head("r024_fifo", 32'h8888_0000, 2'd0);
        nonce_base  = 32'h0000_0000;
        nonce_limit = 32'hFFFF_FFFF;
        job_start   = 1'b1;
        step();
        job_start = 1'b0;
        check("r024_busy", 64'(busy), 64'd1);
        check("r024_ovf_cleared", 64'(overflow), 64'd0);
        job_stop = 1'b1;
        core_req = 4'hF;
        step();
        job_stop = 1'b0;
        check("r024_grant", 64'(core_grant), 64'd0);
        check("r024_busy_off", 64'(busy), 64'd0);
        check("r024_done", 64'(done), 64'd0);
        step();
        check("r024_idle_grant", 64'(core_grant), 64'd0);
        check("r024_idle_done", 64'(done), 64'd0);
        check_head("r024_kept", 32'h8888_0000, 2'd0);

        // Reset mid-job with two results queued.
        core_req    = '0;
        nonce_base  = 32'h5000_0000;
        nonce_limit = 32'h5FFF_FFFF;
        job_start   = 1'b1;
        step();
        job_start = 1'b0;
        check("r025_busy", 64'(busy), 64'd1);
        check("r025_fifo", 64'(res_valid), 64'd1);
        reset_reset_n = 1'b0;
        core_req      = 4'hF;
        step();
        reset_reset_n = 1'b1;
        check("r025_grant", 64'(core_grant), 64'd0);
        check("r025_start", 64'(core_nonce_start), 64'd0);
        check("r025_end", 64'(core_nonce_end), 64'd0);
        check("r025_res_valid", 64'(res_valid), 64'd0);
        check("r025_res_nonce", 64'(res_nonce), 64'd0);
        check("r025_res_core", 64'(res_core), 64'd0);
        check("r025_busy_off", 64'(busy), 64'd0);
        check("r025_done", 64'(done), 64'd0);
        check("r025_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("r025_no_regrant", 64'(core_grant), 64'd0);
            check("r025_stay_idle", 64'(busy), 64'd0);
        end
        job_start = 1'b1;
        step();
        job_start = 1'b0;
        step();
        check("r025_new_grant", 64'(core_grant), 64'h1);
        check("r025_new_start", 64'(core_nonce_start), 64'h5000_0000);
        check("r025_new_end", 64'(core_nonce_end), 64'h500F_FFFF);
        job_stop = 1'b1;
        step();
        job_stop = 1'b0;
        check("r025_stop_grant", 64'(core_grant), 64'd0);
        check("r025_stop_busy", 64'(busy), 64'd0);
        step();
        check("r025_stop_done", 64'(done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nonce_dispatcher.md
NONCE_DISPATCHER -- requirements
Module: nonce_dispatcher

Interface
REQ-001 Parameters SHALL be: NUM_CORES, default 4, number of hash cores; CHUNK_LOG2, default 20, log2 of nonces per grant; FIFO_DEPTH, default 4, result FIFO entries.
REQ-002 Ports SHALL be, in order:
- clk_clk  in  1  sole clock
- reset_reset_n  in  1  synchronous, active-low reset
- job_start  in  1  one-cycle pulse; latch new job
- job_stop  in  1  one-cycle pulse; abort job
- nonce_base  in  32  first nonce of job
- nonce_limit  in  32  last nonce of job, inclusive
- core_req  in  NUM_CORES  core i idle, requesting a range
- core_grant  out  NUM_CORES  one-hot, one-cycle grant
- core_nonce_start  out  32  range start, valid with grant
- core_nonce_end  out  32  range end inclusive, valid with grant
- core_found  in  NUM_CORES  one-cycle pulse, core i found nonce
- core_found_nonce  in  32*NUM_CORES  core i nonce at bits [32i+31:32i]
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_nonce  out  32  result nonce
- res_core  out  log2(NUM_CORES)  result source core
- busy  out  1  job active (not IDLE)
- done  out  1  one-cycle pulse on job exhaustion
- overflow  out  1  sticky; a found result was dropped

Function
REQ-003 FSM states SHALL be IDLE, DISPATCH, DRAIN; all transitions registered.
REQ-004 IDLE: job_start -> next_nonce <= nonce_base, overflow <= 0, go DISPATCH next cycle; other inputs ignored.
REQ-005 DISPATCH: at most one grant per cycle, to a core with core_req=1, chosen round-robin starting at the index after the last granted core.
REQ-006 Grant outputs SHALL be registered: core_grant, core_nonce_start=next_nonce, core_nonce_end=min(next_nonce+2^CHUNK_LOG2-1, nonce_limit) appear together for exactly one cycle.
REQ-007 A granted core's core_req SHALL be masked for the 2 cycles following its grant (req-drop latency).
REQ-008 On each grant next_nonce SHALL advance by 2^CHUNK_LOG2 using 33-bit arithmetic; if carry-out, or new value > nonce_limit, go DRAIN after this grant.
REQ-009 nonce_base > nonce_limit SHALL issue no grant: DISPATCH -> DRAIN immediately.
REQ-010 DRAIN: no grants; when all core_req bits are 1 (and unmasked), pulse done for one cycle and go IDLE.
REQ-011 job_stop in DISPATCH or DRAIN SHALL go IDLE next cycle with no done pulse and no further grants; job_stop has priority over a same-cycle grant; job_start outside IDLE ignored.
REQ-012 busy SHALL be 1 exactly in DISPATCH and DRAIN.
REQ-013 Each core SHALL have a one-entry pending register; core_found[i] loads it with core i's nonce in any state.
REQ-014 core_found[i] while pending[i] already set and not freed that cycle SHALL drop the new nonce and set overflow.
REQ-015 Each cycle the lowest-index pending entry SHALL move to the result FIFO if not full (or full and popped that cycle).
REQ-016 res_valid = FIFO non-empty; pop on res_valid&res_ready; res_nonce/res_core stable while res_valid&!res_ready; order preserved.
REQ-017 Pending registers and FIFO SHALL survive job_stop and job end; only reset clears them.

Reset
REQ-018 reset_reset_n=0 at a clk_clk edge SHALL force: state IDLE, core_grant=0, core_nonce_start=0, core_nonce_end=0, res_valid=0, res_nonce=0, res_core=0, busy=0, done=0, overflow=0, next_nonce=0, round-robin pointer so core 0 is first, pending and FIFO empty.
REQ-019 Reset mid-job SHALL abort without done pulse; first grant after release needs a new job_start.

Verification
REQ-020 base=0, limit=0x003FFFFF, CHUNK_LOG2=20, all cores requesting -> grants cores 0,1,2,3 with starts 0x0, 0x100000, 0x200000, 0x300000; then DRAIN; done once after all req high.
REQ-021 base=0xFFF00000, limit=0xFFFFFFFF -> single grant start 0xFFF00000 end 0xFFFFFFFF; carry detected, DRAIN, no wrapped grant at 0.
REQ-022 base=0x10, limit=0x8 -> no grants, done pulse, busy returns 0.
REQ-023 core_found on cores 1 and 3 same cycle, res_ready=0 -> two FIFO entries, core 1 first; second core_found on core 1 before free -> overflow=1.
REQ-024 job_stop asserted same cycle as eligible core_req -> no grant, IDLE next cycle, no done, FIFO contents retained.
REQ-025 Reset pulled low during DISPATCH with FIFO holding 2 results -> all outputs at REQ-018 values next cycle.
